pipe_hazard_ctrl: RTL and testbench

//  Hazard/forwarding controller that drives the D->E pipeline register's clr and the F/D

---
 rtl/pipe_hazard_pkg.sv | 18 +
 rtl/hazard_fwd_sel.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// Forwarding select encoding and redirect FSM states.
package pipe_hazard_pkg;

    localparam int unsigned REG_AW_DEF = 3;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select: compares an Execute source tag against M and W dest tags.
// The M stage holds the younger result, so it wins over W.
module hazard_fwd_sel
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] ra_e_i,
    input  logic [REG_AW-1:0] wa_m_i,
    input  logic [REG_AW-1:0] wa_w_i,
    input  logic              reg_write_m_i,
    input  logic              reg_write_w_i,
    output fwd_sel_e          sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (reg_write_m_i && (wa_m_i == ra_e_i)) begin
            sel_o = FWD_MEM;
        end else if (reg_write_w_i && (wa_w_i == ra_e_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use stall, branch-redirect flush FSM and
// saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned REG_AW       = REG_AW_DEF,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] RA1E,
    input  logic [REG_AW-1:0] RA2E,
    input  logic [REG_AW-1:0] WA3E,
    input  logic [REG_AW-1:0] WA3M,
    input  logic [REG_AW-1:0] WA3W,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              BranchTakenE,
    input  logic              PCSrcW,
    input  logic              cnt_clr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned        RcntW    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [RcntW-1:0]   RcntInit = RcntW'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CntMax   = '1;

    hz_state_e          state_q, state_d;
    logic [RcntW-1:0]   rcnt_q, rcnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    fwd_sel_e fwd_a, fwd_b;
    logic     ldstall, flush_d, flush_e, stall;

    hazard_fwd_sel #(
        .REG_AW (REG_AW)
    ) u_fwd_a (
        .ra_e_i        (RA1E),
        .wa_m_i        (WA3M),
        .wa_w_i        (WA3W),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd_a)
    );

    hazard_fwd_sel #(
        .REG_AW (REG_AW)
    ) u_fwd_b (
        .ra_e_i        (RA2E),
        .wa_m_i        (WA3M),
        .wa_w_i        (WA3W),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd_b)
    );

    assign ldstall = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
    assign flush_d = BranchTakenE | PCSrcW | (state_q == REDIRECT);
    assign flush_e = BranchTakenE | (ldstall & ~BranchTakenE);
    // A flushed Decode holds a wrong-path instruction, so stalling it is pointless.
    assign stall   = ldstall & ~BranchTakenE & ~flush_d;

    assign ForwardAE = reset_n ? fwd_a : FWD_RF;
    assign ForwardBE = reset_n ? fwd_b : FWD_RF;
    assign StallF    = reset_n & stall;
    assign StallD    = reset_n & stall;
    assign FlushD    = reset_n & flush_d;
    assign FlushE    = reset_n & flush_e;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        unique case (state_q)
            RUN: begin
                if (BranchTakenE && (FLUSH_CYCLES > 1)) begin
                    state_d = REDIRECT;
                    rcnt_d  = RcntInit;
                end
            end
            REDIRECT: begin
                if (BranchTakenE) begin
                    rcnt_d = RcntInit;
                end else if (rcnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    rcnt_d = rcnt_q - RcntW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && (stall_cnt_q != CntMax)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush_e && (flush_cnt_q != CntMax)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            rcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by random stimulus
// compared against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned AW   = 3;
    localparam int unsigned FC   = 2;
    localparam int unsigned CW   = 3;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, PCSrcW, cnt_clr;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, FlushD, FlushE;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: remaining redirect cycles and perf counts.
    int rem = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_AW       (AW),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA1E         (RA1E),
        .RA2E         (RA2E),
        .WA3E         (WA3E),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .RegWriteE    (RegWriteE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .BranchTakenE (BranchTakenE),
        .PCSrcW       (PCSrcW),
        .cnt_clr      (cnt_clr),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fwd_model(input logic [AW-1:0] ra);
        if (RegWriteM && WA3M == ra) return 2;
        if (RegWriteW && WA3W == ra) return 1;
        return 0;
    endfunction

    task automatic idle();
        RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
        WA3E = '0; WA3M = '0; WA3W = '0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; BranchTakenE = 1'b0; PCSrcW = 1'b0; cnt_clr = 1'b0;
    endtask

    // Check every output against the model, then clock once and advance the model.
    task automatic step();
        int ld, fd, st, fe;
        #1;
        ld = (MemtoRegE && RegWriteE && (WA3E == RA1D || WA3E == RA2D)) ? 1 : 0;
        fd = (BranchTakenE || PCSrcW || rem > 0) ? 1 : 0;
        st = (ld == 1 && fd == 0) ? 1 : 0;
        fe = (BranchTakenE || ld == 1) ? 1 : 0;
        chk("ForwardAE", 32'(ForwardAE), fwd_model(RA1E));
        chk("ForwardBE", 32'(ForwardBE), fwd_model(RA2E));
        chk("StallF", 32'(StallF), st);
        chk("StallD", 32'(StallD), st);
        chk("FlushD", 32'(FlushD), fd);
        chk("FlushE", 32'(FlushE), fe);
        chk("stall_cnt", 32'(stall_cnt), m_stall);
        chk("flush_cnt", 32'(flush_cnt), m_flush);
        @(posedge clk);
        if (cnt_clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (st == 1 && m_stall < CMAX) m_stall++;
            if (fe == 1 && m_flush < CMAX) m_flush++;
        end
        if (BranchTakenE) rem = (FC > 1) ? FC : 0;
        else if (rem > 0) rem--;
        @(negedge clk);
    endtask

    task automatic set_ldstall();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 3'd2; RA2D = 3'd2;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        RA1E = 3'd3; WA3M = 3'd3; RegWriteM = 1'b1;
        set_ldstall();
        BranchTakenE = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ForwardAE", 32'(ForwardAE), 0);
        chk("rst_StallD", 32'(StallD), 0);
        chk("rst_FlushD", 32'(FlushD), 0);
        chk("rst_FlushE", 32'(FlushE), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        reset_n = 1'b1;
        idle();
        step();

        // Forwarding priority: M over W, then W alone.
        RA1E = 3'd3; WA3M = 3'd3; RegWriteM = 1'b1; WA3W = 3'd3; RegWriteW = 1'b1;
        #1 chk("t1_mem", 32'(ForwardAE), 2);
        step();
        RegWriteM = 1'b0;
        #1 chk("t1_wb", 32'(ForwardAE), 1);
        step();

        // Load-use stall for one cycle.
        idle();
        set_ldstall();
        #1 chk("t2_StallF", 32'(StallF), 1);
        chk("t2_FlushE", 32'(FlushE), 1);
        step();
        idle();
        #1 chk("t2_stall_cnt", 32'(stall_cnt), 1);
        step();

        // Taken branch: FlushD for three cycles, FlushE for one.
        BranchTakenE = 1'b1;
        step();
        BranchTakenE = 1'b0;
        #1 chk("t3_c1_FlushD", 32'(FlushD), 1);
        chk("t3_c1_FlushE", 32'(FlushE), 0);
        step();
        #1 chk("t3_c2_FlushD", 32'(FlushD), 1);
        step();
        #1 chk("t3_c3_FlushD", 32'(FlushD), 0);
        step();

        // Branch and load-use in the same cycle: branch wins.
        set_ldstall();
        BranchTakenE = 1'b1;
        #1 chk("t4_StallD", 32'(StallD), 0);
        chk("t4_FlushD", 32'(FlushD), 1);
        step();
        idle();
        repeat (3) step();

        // Reset in the middle of a redirect.
        BranchTakenE = 1'b1;
        step();
        BranchTakenE = 1'b0;
        set_ldstall();
        RA1E = 3'd5; WA3M = 3'd5; RegWriteM = 1'b1;
        #1 reset_n = 1'b0;
        #1 chk("t5_ForwardAE", 32'(ForwardAE), 0);
        chk("t5_StallF", 32'(StallF), 0);
        chk("t5_FlushD", 32'(FlushD), 0);
        chk("t5_FlushE", 32'(FlushE), 0);
        rem = 0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        #1 chk("t5_post_FlushD", 32'(FlushD), 0);
        step();

        // Saturation of the 3-bit stall counter, then synchronous clear.
        set_ldstall();
        repeat (10) step();
        #1 chk("t6_sat", 32'(stall_cnt), 7);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        idle();
        #1 chk("t6_clr", 32'(stall_cnt), 0);
        step();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            RA1D = AW'($urandom_range(7)); RA2D = AW'($urandom_range(7));
            RA1E = AW'($urandom_range(7)); RA2E = AW'($urandom_range(7));
            WA3E = AW'($urandom_range(7)); WA3M = AW'($urandom_range(7));
            WA3W = AW'($urandom_range(7));
            RegWriteE = 1'($urandom_range(1)); RegWriteM = 1'($urandom_range(1));
            RegWriteW = 1'($urandom_range(1)); MemtoRegE = 1'($urandom_range(1));
            BranchTakenE = ($urandom_range(5) == 0);
            PCSrcW = ($urandom_range(7) == 0);
            cnt_clr = ($urandom_range(19) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
